// File: rtl/argmax_classifier_if.sv
// rtl/argmax_classifier_if.sv - logit stream and result handshake bundle for argmax_classifier
// Signals (slave = classifier side, master = producer/consumer side):
//   blob_din_rdy   slave->master  classifier can take a logit beat
//   blob_din_en    master->slave  logit beat valid
//   blob_din_eop   master->slave  last beat of the image
//   blob_din       master->slave  {logit[2k+1], logit[2k]}, signed DW-bit lanes
//   result_valid   slave->master  result held stable while high
//   result_ready   master->slave  consumer takes the result
//   result_class   slave->master  index of the maximum logit
//   result_score   slave->master  value of the maximum logit
//   result_err     slave->master  beat count differed from the expected count
//   result_class2  slave->master  runner-up index, present only with ARGMAX_TOP2_EN
interface argmax_classifier_if #(
  parameter int DW    = 16,
  parameter int IDX_W = 4
);
  logic              blob_din_rdy;
  logic              blob_din_en;
  logic              blob_din_eop;
  logic [2*DW-1:0]   blob_din;
  logic              result_valid;
  logic              result_ready;
  logic [IDX_W-1:0]  result_class;
  logic [DW-1:0]     result_score;
  logic              result_err;
`ifdef ARGMAX_TOP2_EN
  logic [IDX_W-1:0]  result_class2;

  modport slave (
    input  blob_din_en, blob_din_eop, blob_din, result_ready,
    output blob_din_rdy, result_valid, result_class, result_score, result_err, result_class2
  );
  modport master (
    output blob_din_en, blob_din_eop, blob_din, result_ready,
    input  blob_din_rdy, result_valid, result_class, result_score, result_err, result_class2
  );
`else
  modport slave (
    input  blob_din_en, blob_din_eop, blob_din, result_ready,
    output blob_din_rdy, result_valid, result_class, result_score, result_err
  );
  modport master (
    output blob_din_en, blob_din_eop, blob_din, result_ready,
    input  blob_din_rdy, result_valid, result_class, result_score, result_err
  );
`endif
endinterface

// File: rtl/argmax_classifier.sv
// rtl/argmax_classifier.sv - argmax over a two-logits-per-beat stream with held result
// Ports:
//   clk  rising-edge clock
//   rst  synchronous reset, active-high
//   bus  argmax_classifier_if.slave: logit stream in (blob_din_*), result out (result_*)
// Optional feature macro: ARGMAX_TOP2_EN (adds runner-up tracking and result_class2).
module argmax_classifier #(
  parameter int NUM_CLASS = 10,
  parameter int DW        = 16,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  argmax_classifier_if.slave bus
);
  localparam int NUM_BEATS = NUM_CLASS / 2;
  localparam int BCW       = $clog2(NUM_BEATS + 1);
  localparam logic signed [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic                  rdy, valid, accept, take;

  logic [BCW-1:0]        beat_cnt;
  logic signed [DW-1:0]  max_val, max_val_nxt;
  logic [IDX_W-1:0]      max_idx, max_idx_nxt;
  logic                  err, err_nxt;

  logic signed [DW-1:0]  lane0, lane1, cand_val;
  logic [IDX_W-1:0]      cand_idx;
  logic                  in_range, first;

  logic [IDX_W-1:0]      res_class;
  logic [DW-1:0]         res_score;
  logic                  res_err;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = 1'b1;
    valid     = 1'b0;
    case (state)
      S_IDLE:    if (accept) state_nxt = bus.blob_din_eop ? S_DONE : S_COLLECT;
      S_COLLECT: if (accept && bus.blob_din_eop) state_nxt = S_DONE;
      S_DONE: begin
        rdy   = 1'b0;
        valid = 1'b1;
        if (bus.result_ready) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  assign accept = bus.blob_din_en && rdy;
  assign take   = valid && bus.result_ready;

  // ---------------- per-beat datapath ----------------
  assign lane0    = bus.blob_din[DW-1:0];
  assign lane1    = bus.blob_din[2*DW-1:DW];
  assign in_range = beat_cnt < BCW'(NUM_BEATS);
  assign first    = beat_cnt == '0;

  // Lane0 wins a tie inside the beat, so the lower index is kept.
  always_comb begin
    if (lane1 > lane0) begin
      cand_val = lane1;
      cand_idx = IDX_W'({beat_cnt, 1'b1});
    end else begin
      cand_val = lane0;
      cand_idx = IDX_W'({beat_cnt, 1'b0});
    end
  end

  // The first beat seeds the max directly so an all-most-negative image
  // still reports index 0 rather than relying on the reset value.
  always_comb begin
    max_val_nxt = max_val;
    max_idx_nxt = max_idx;
    if (in_range && (first || cand_val > max_val)) begin
      max_val_nxt = cand_val;
      max_idx_nxt = cand_idx;
    end
  end

  // Overlong images (beats past the expected count) and early eop both flag.
  assign err_nxt = err || !in_range ||
                   (bus.blob_din_eop && beat_cnt != BCW'(NUM_BEATS - 1));

  always_ff @(posedge clk) begin
    if (rst || take) begin
      beat_cnt <= '0;
      max_val  <= MOST_NEG;
      max_idx  <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (in_range) beat_cnt <= beat_cnt + BCW'(1);
      max_val <= max_val_nxt;
      max_idx <= max_idx_nxt;
      err     <= err_nxt;
    end
  end

  // Result registers load only on the eop beat and hold through DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_class <= '0;
      res_score <= '0;
      res_err   <= 1'b0;
    end else if (accept && bus.blob_din_eop) begin
      res_class <= max_idx_nxt;
      res_score <= max_val_nxt;
      res_err   <= err_nxt;
    end
  end

`ifdef ARGMAX_TOP2_EN
  logic signed [DW-1:0]  sec_val, sec_val_nxt, lose_val;
  logic [IDX_W-1:0]      sec_idx, sec_idx_nxt, lose_idx, res_class2;

  // Winner is inserted before loser; a loser never exceeds the winner, so
  // it can only ever compete for the second slot.
  always_comb begin
    if (lane1 > lane0) begin
      lose_val = lane0;
      lose_idx = IDX_W'({beat_cnt, 1'b0});
    end else begin
      lose_val = lane1;
      lose_idx = IDX_W'({beat_cnt, 1'b1});
    end
    sec_val_nxt = sec_val;
    sec_idx_nxt = sec_idx;
    if (in_range) begin
      if (first) begin
        sec_val_nxt = lose_val;
        sec_idx_nxt = lose_idx;
      end else if (cand_val > max_val) begin
        if (lose_val > max_val) begin
          sec_val_nxt = lose_val;
          sec_idx_nxt = lose_idx;
        end else begin
          sec_val_nxt = max_val;
          sec_idx_nxt = max_idx;
        end
      end else if (cand_val > sec_val) begin
        sec_val_nxt = cand_val;
        sec_idx_nxt = cand_idx;
      end else if (lose_val > sec_val) begin
        sec_val_nxt = lose_val;
        sec_idx_nxt = lose_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || take) begin
      sec_val <= MOST_NEG;
      sec_idx <= '0;
    end else if (accept) begin
      sec_val <= sec_val_nxt;
      sec_idx <= sec_idx_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                              res_class2 <= '0;
    else if (accept && bus.blob_din_eop)  res_class2 <= sec_idx_nxt;
  end

  assign bus.result_class2 = res_class2;
`endif

  assign bus.blob_din_rdy = rdy;
  assign bus.result_valid = valid;
  assign bus.result_class = res_class;
  assign bus.result_score = res_score;
  assign bus.result_err   = res_err;
endmodule
